cellrv32_pwm_capture: RTL and testbench
=======================================

# cellrv32_pwm_capture

PWM input capture unit: measures period and high time of up to four external PWM signals, with prescaler-based time base from the shared processor clock generator. It sits in the IO space as a memory-mapped peripheral beside the PWM controller, uses the same host bus handshake, and decodes PWM waveforms instead of generating them.

## Interface
- NUM_CHANNELS, 0, number of implemented capture channels (0..4); values above 4 are a config error.
- clk_i  in  1  global clock line
- rst_i  in  1  reset, synchronous, active-high
- addr_i  in  32  access address
- rden_i  in  1  read enable
- wren_i  in  1  write enable
- data_i  in  32  write data
- data_o  out  32  read data, registered
- ack_o  out  1  transfer acknowledge
- clkgen_en_o  out  1  clock generator enable
- clkgen_i  in  8  prescaled clock ticks from clock generator
- pwm_i  in  4  asynchronous PWM inputs; bits >= NUM_CHANNELS ignored
- irq_o  out  1  capture interrupt, level (see Configuration)

## Operation
- Decode: module selected when addr_i[hi:lo] matches pwmcap_base_c (package constants pwmcap_base_c, pwmcap_size_c = 32 bytes); word offset addr_i[4:2].
- Map: 0x00 CTRL, 0x04 STATUS, 0x08+4*i CH_i (i=0..3), 0x18/0x1C reserved (read 0, writes ignored).
- CTRL: bit0 EN, bits3:1 PRSC, bits11:8 IE (per channel). Others read 0.
- STATUS: bits3:0 VALID (read-only), bits7:4 OVF (sticky, write-1-to-clear).
- CH_i: [31:16] PERIOD, [15:0] HIGH, read-only; unimplemented channels read 0.
- clkgen_en_o = EN; tick = clkgen_i[PRSC].
- Per channel: 2-FF synchronizer, then edge detector (prev-sample register) producing rise/fall pulses.
- Per-channel FSM: IDLE -> (rise) HIGH -> (fall) LOW -> (rise) HIGH ...
- On rise in IDLE: cnt <= tick ? 1 : 0; go HIGH.
- HIGH/LOW: cnt increments on each tick; on fall in HIGH: hi_shadow <= cnt.
- On rise in LOW: CH_i <= {cnt, hi_shadow} atomically, VALID[i] <= 1, cnt <= tick ? 1 : 0, go HIGH. Count = ticks in [edge, next edge).
- Saturation: cnt reaching 0xFFFF in HIGH or LOW -> OVF[i] <= 1, go IDLE, CH_i unchanged.
- New capture overwrites CH_i even if VALID[i] already set.
- Read of CH_i clears VALID[i]; capture completing same cycle wins (VALID stays 1, data_o returns old CH_i).
- EN=0: all FSMs IDLE, cnt 0; CH_i, VALID, OVF retained. Clearing OVF bit and OVF set same cycle: set wins.
- Channels >= NUM_CHANNELS: no logic, FSM absent, VALID/OVF bits read 0.

## Timing
- Reset: data_o 0, ack_o 0, clkgen_en_o 0, irq_o 0; CTRL, STATUS, CH_i, cnt all 0; FSMs IDLE.
- ack_o asserted exactly one cycle after any selected rden_i or wren_i; data_o valid in that cycle, 0 otherwise.
- Input edge to FSM action: 3 cycles (2 sync + edge register).
- VALID/CH_i update visible to a read issued the cycle after the capture.
- Reset mid-measurement: all state returns to reset values next edge of clk_i; no partial result written.

## Configuration
- CELLRV32_PWMCAP_IRQ_EN defined: IE bits writable; irq_o = OR over i of (VALID[i] & IE[i]), registered, one cycle after VALID update.
- Not defined: IE bits read 0, writes ignored; irq_o tied 0.

## Test plan
- Reset, read all registers -> all read 0, ack_o one cycle after each rden_i.
- clkgen_i all ones, EN=1 PRSC=0, pwm_i[0] period 100 clk high 25 -> after second rise CH0 = 0x0064_0019, VALID[0]=1; read CH0 -> VALID[0]=0.
- pwm_i[1] held high 70000 clk with EN=1 -> OVF[1]=1, FSM IDLE, CH1 unchanged; write STATUS 0x20 -> OVF[1]=0.
- clkgen_i[2] ticking every 4th clk, PRSC=2, period 400 clk high 100 -> CH0 = 0x0064_0019.
- Capture completing in same cycle as CH0 read -> data_o old value, VALID[0] remains 1.
- With CELLRV32_PWMCAP_IRQ_EN, IE=0x1, valid capture on ch0 -> irq_o=1; read CH0 -> irq_o=0 next cycle; without macro irq_o stays 0.

Source files
------------

// File: rtl/cellrv32_pwm_capture.sv
// PWM input capture: per-channel period/high-time measurement on a prescaled tick.
// Optional feature macro: CELLRV32_PWMCAP_IRQ_EN (per-channel interrupt enables and irq_o).
`timescale 1ns/1ps
module cellrv32_pwm_capture #(
    parameter int NUM_CHANNELS = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic        rden_i,
    input  logic        wren_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        ack_o,
    output logic        clkgen_en_o,
    input  logic [7:0]  clkgen_i,
    input  logic [3:0]  pwm_i,
    output logic        irq_o
);
    localparam logic [31:0] pwmcap_base_c = 32'hFFFF_FE80;
    localparam int          pwmcap_size_c = 32;
    localparam int          lo_c          = $clog2(pwmcap_size_c);
    localparam int          impl_c        = (1 << NUM_CHANNELS) - 1;
    localparam logic [3:0]  impl_mask_c   = impl_c[3:0];

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_HIGH = 2'b01;
    localparam logic [1:0] S_LOW  = 2'b10;

    logic        sel, rd_acc, wr_acc;
    logic [2:0]  word;
    logic        en_q, ack_q;
    logic [2:0]  prsc_q;
    logic [3:0]  valid_q, valid_d, ovf_q, ovf_d, ovf_clr, rd_clr, ie_rd;
    logic [31:0] rdata_q, rd_mux;
    logic        tick;
    logic [3:0]  cap_w, sat_w;
    logic [3:0][31:0] ch_w;
    logic        unused_misc;

    assign sel    = (addr_i[31:lo_c] == pwmcap_base_c[31:lo_c]);
    assign word   = addr_i[4:2];
    assign rd_acc = sel & rden_i;
    assign wr_acc = sel & wren_i;
    assign tick   = clkgen_i[prsc_q];

    assign data_o      = rdata_q;
    assign ack_o       = ack_q;
    assign clkgen_en_o = en_q;
    assign unused_misc = ^{addr_i[1:0], data_i[31:12], tick};

    for (genvar i = 0; i < 4; i++) begin : g_ch
        if (i < NUM_CHANNELS) begin : g_impl
            logic        sync1_q, sync2_q, prev_q, rise, fall, cap, sat;
            logic [1:0]  state_q, state_d;
            logic [15:0] cnt_q, cnt_d, hi_q, hi_d, cnt_inc;
            logic [31:0] ch_q, ch_d;

            assign rise    = sync2_q & ~prev_q;
            assign fall    = ~sync2_q & prev_q;
            assign cnt_inc = cnt_q + {15'd0, tick};

            // cnt counts ticks in [edge, next edge); the tick of a rising edge opens the new period
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                hi_d    = hi_q;
                ch_d    = ch_q;
                cap     = 1'b0;
                sat     = 1'b0;
                if (!en_q) begin
                    state_d = S_IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    case (state_q)
                        S_IDLE: if (rise) begin
                            state_d = S_HIGH;
                            cnt_d   = {15'd0, tick};
                        end
                        S_HIGH: if (cnt_inc == 16'hFFFF) begin
                            sat     = 1'b1;
                            state_d = S_IDLE;
                            cnt_d   = 16'd0;
                        end else begin
                            cnt_d = cnt_inc;
                            if (fall) begin
                                hi_d    = cnt_q;
                                state_d = S_LOW;
                            end
                        end
                        S_LOW: if (rise) begin
                            cap     = 1'b1;
                            ch_d    = {cnt_q, hi_q};
                            cnt_d   = {15'd0, tick};
                            state_d = S_HIGH;
                        end else if (cnt_inc == 16'hFFFF) begin
                            sat     = 1'b1;
                            state_d = S_IDLE;
                            cnt_d   = 16'd0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                        default: begin
                            state_d = S_IDLE;
                            cnt_d   = 16'd0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    prev_q  <= 1'b0;
                    state_q <= S_IDLE;
                    cnt_q   <= 16'd0;
                    hi_q    <= 16'd0;
                    ch_q    <= 32'd0;
                end else begin
                    sync1_q <= pwm_i[i];
                    sync2_q <= sync1_q;
                    prev_q  <= sync2_q;
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    hi_q    <= hi_d;
                    ch_q    <= ch_d;
                end
            end

            assign cap_w[i] = cap;
            assign sat_w[i] = sat;
            assign ch_w[i]  = ch_q;
        end else begin : g_none
            logic unused_pwm;
            assign unused_pwm = pwm_i[i];
            assign cap_w[i]   = 1'b0;
            assign sat_w[i]   = 1'b0;
            assign ch_w[i]    = 32'd0;
        end
    end

    // A capture in the same cycle as a CH read or an OVF clear keeps the flag set
    always_comb begin
        rd_clr = 4'd0;
        for (int i = 0; i < 4; i++) begin
            rd_clr[i] = rd_acc && (word == 3'(i + 2));
        end
        ovf_clr = (wr_acc && word == 3'd1) ? data_i[7:4] : 4'd0;
        valid_d = ((valid_q & ~rd_clr) | cap_w) & impl_mask_c;
        ovf_d   = ((ovf_q & ~ovf_clr) | sat_w) & impl_mask_c;
        case (word)
            3'd0:    rd_mux = {20'd0, ie_rd, 4'd0, prsc_q, en_q};
            3'd1:    rd_mux = {24'd0, ovf_q, valid_q};
            3'd2:    rd_mux = ch_w[0];
            3'd3:    rd_mux = ch_w[1];
            3'd4:    rd_mux = ch_w[2];
            3'd5:    rd_mux = ch_w[3];
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ack_q   <= 1'b0;
            rdata_q <= 32'd0;
            en_q    <= 1'b0;
            prsc_q  <= 3'd0;
            valid_q <= 4'd0;
            ovf_q   <= 4'd0;
        end else begin
            ack_q   <= rd_acc | wr_acc;
            rdata_q <= rd_acc ? rd_mux : 32'd0;
            if (wr_acc && word == 3'd0) begin
                en_q   <= data_i[0];
                prsc_q <= data_i[3:1];
            end
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef CELLRV32_PWMCAP_IRQ_EN
    logic [3:0] ie_q;
    logic       irq_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ie_q  <= 4'd0;
            irq_q <= 1'b0;
        end else begin
            if (wr_acc && word == 3'd0) begin
                ie_q <= data_i[11:8];
            end
            irq_q <= |(valid_q & ie_q);
        end
    end
    assign ie_rd = ie_q;
    assign irq_o = irq_q;
`else
    logic unused_ie;
    assign unused_ie = ^data_i[11:8];
    assign ie_rd     = 4'd0;
    assign irq_o     = 1'b0;
`endif
endmodule

// File: tb/tb_cellrv32_pwm_capture.sv
// Directed bench for cellrv32_pwm_capture: register map, capture, overflow, prescaler, read races, reset.
`timescale 1ns/1ps
module tb_cellrv32_pwm_capture;
  localparam logic [31:0] BASE = 32'hFFFF_FE80;
`ifdef CELLRV32_PWMCAP_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic        clk, rst;
  logic [31:0] addr_i, data_i, data_o;
  logic        rden_i, wren_i, ack_o, clkgen_en_o, irq_o;
  logic [7:0]  clkgen_i;
  logic [3:0]  pwm_i;
  int          checks = 0;
  int          fails = 0;
  bit          div_mode = 1'b0;
  int          div_cnt = 0;

  cellrv32_pwm_capture #(.NUM_CHANNELS(4)) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr_i), .rden_i(rden_i), .wren_i(wren_i),
    .data_i(data_i), .data_o(data_o), .ack_o(ack_o), .clkgen_en_o(clkgen_en_o),
    .clkgen_i(clkgen_i), .pwm_i(pwm_i), .irq_o(irq_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // clock generator model: all taps ticking, or only tap 2 every 4th cycle
  always @(negedge clk) begin
    if (div_mode) begin
      clkgen_i = (div_cnt == 0) ? 8'h04 : 8'h00;
      div_cnt = (div_cnt + 1) % 4;
    end else begin
      clkgen_i = 8'hFF;
      div_cnt = 0;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks: called at a negedge, return at a negedge
  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic ack);
    addr_i = a; rden_i = 1'b1;
    @(negedge clk);
    rden_i = 1'b0;
    d = data_o; ack = ack_o;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, output logic ack);
    addr_i = a; data_i = d; wren_i = 1'b1;
    @(negedge clk);
    wren_i = 1'b0;
    ack = ack_o;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic ack;
    checks++; if ({data_o, ack_o, clkgen_en_o, irq_o} !== 35'd0) begin fails++; $display("FAIL reset_outs got=%h exp=0", {data_o, ack_o, clkgen_en_o, irq_o}); end
    for (int off = 0; off < 8; off++) begin
      bus_read(BASE + 32'(off * 4), d, ack);
      checks++; if (d !== 32'd0) begin fails++; $display("FAIL reset_rd off=%0h got=%h exp=%h", off * 4, d, 32'd0); end
      checks++; if (ack !== 1'b1) begin fails++; $display("FAIL reset_ack off=%0h got=%b exp=1", off * 4, ack); end
    end
    @(negedge clk);
    checks++; if (ack_o !== 1'b0) begin fails++; $display("FAIL ack_drop got=%b exp=0", ack_o); end
    bus_read(32'h0000_0000, d, ack);
    checks++; if (ack !== 1'b0) begin fails++; $display("FAIL unsel_ack got=%b exp=0", ack); end
  endtask

  task automatic test_ctrl();
    logic [31:0] d, exp;
    logic ack;
    exp = IRQ_EN ? 32'h0000_0F0F : 32'h0000_000F;
    bus_write(BASE, 32'hFFFF_FFFF, ack);
    checks++; if (ack !== 1'b1) begin fails++; $display("FAIL wr_ack got=%b exp=1", ack); end
    bus_read(BASE, d, ack);
    checks++; if (d !== exp) begin fails++; $display("FAIL ctrl_rd got=%h exp=%h", d, exp); end
    checks++; if (clkgen_en_o !== 1'b1) begin fails++; $display("FAIL clkgen_en got=%b exp=1", clkgen_en_o); end
    bus_write(BASE + 32'h18, 32'hFFFF_FFFF, ack);
    bus_read(BASE + 32'h18, d, ack);
    checks++; if (d !== 32'd0) begin fails++; $display("FAIL reserved_rd got=%h exp=0", d); end
    bus_write(BASE, 32'd0, ack);
  endtask

  task automatic test_capture_basic();
    logic [31:0] d;
    logic ack;
    bus_write(BASE, 32'h0000_0101, ack);
    pwm_i[0] = 1'b1; tick_n(25);
    pwm_i[0] = 1'b0; tick_n(40);
    bus_read(BASE + 32'h4, d, ack);
    checks++; if (d !== 32'd0) begin fails++; $display("FAIL status_midperiod got=%h exp=0", d); end
    tick_n(34);
    pwm_i[0] = 1'b1; tick_n(5);
    checks++; if (irq_o !== IRQ_EN) begin fails++; $display("FAIL irq_set got=%b exp=%b", irq_o, IRQ_EN); end
    bus_read(BASE + 32'h4, d, ack);
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL status_valid0 got=%h exp=%h", d, 32'h1); end
    bus_read(BASE + 32'h8, d, ack);
    checks++; if (d !== 32'h0064_0019) begin fails++; $display("FAIL ch0_basic got=%h exp=%h", d, 32'h0064_0019); end
    bus_read(BASE + 32'h4, d, ack);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL status_rdclr got=%h exp=0", d); end
    tick_n(2);
    checks++; if (irq_o !== 1'b0) begin fails++; $display("FAIL irq_clr got=%b exp=0", irq_o); end
    pwm_i[0] = 1'b0;
    bus_write(BASE, 32'd0, ack);
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic ack;
    bus_write(BASE, 32'h1, ack);
    pwm_i[1] = 1'b1; tick_n(66000);
    bus_read(BASE + 32'h4, d, ack);
    checks++; if (d !== 32'h20) begin fails++; $display("FAIL status_ovf1 got=%h exp=%h", d, 32'h20); end
    bus_read(BASE + 32'hC, d, ack);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL ch1_after_ovf got=%h exp=0", d); end
    bus_write(BASE + 32'h4, 32'h20, ack);
    bus_read(BASE + 32'h4, d, ack);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL status_ovf_clr got=%h exp=0", d); end
    // a fresh period after overflow starts from IDLE
    pwm_i[1] = 1'b0; tick_n(10);
    pwm_i[1] = 1'b1; tick_n(5);
    pwm_i[1] = 1'b0; tick_n(5);
    pwm_i[1] = 1'b1; tick_n(5);
    bus_read(BASE + 32'h4, d, ack);
    checks++; if (d !== 32'h2) begin fails++; $display("FAIL status_valid1 got=%h exp=%h", d, 32'h2); end
    bus_read(BASE + 32'hC, d, ack);
    checks++; if (d !== 32'h000A_0005) begin fails++; $display("FAIL ch1_rearm got=%h exp=%h", d, 32'h000A_0005); end
    pwm_i[1] = 1'b0;
    bus_write(BASE, 32'd0, ack);
  endtask

  task automatic test_prescaler();
    logic [31:0] d;
    logic ack;
    div_mode = 1'b1;
    bus_write(BASE, 32'h5, ack);
    pwm_i[0] = 1'b1; tick_n(100);
    pwm_i[0] = 1'b0; tick_n(300);
    pwm_i[0] = 1'b1; tick_n(6);
    bus_read(BASE + 32'h4, d, ack);
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL status_prsc got=%h exp=%h", d, 32'h1); end
    bus_read(BASE + 32'h8, d, ack);
    checks++; if (d !== 32'h0064_0019) begin fails++; $display("FAIL ch0_prsc got=%h exp=%h", d, 32'h0064_0019); end
    pwm_i[0] = 1'b0;
    bus_write(BASE, 32'd0, ack);
    div_mode = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic ack;
    bus_write(BASE, 32'h1, ack);
    pwm_i[0] = 1'b1; tick_n(20);
    pwm_i[0] = 1'b0; tick_n(30);
    pwm_i[0] = 1'b1; tick_n(30);
    pwm_i[0] = 1'b0; tick_n(30);
    pwm_i[0] = 1'b1; tick_n(2);
    // this read is sampled on the very edge that completes the second capture
    bus_read(BASE + 32'h8, d, ack);
    checks++; if (d !== 32'h0032_0014) begin fails++; $display("FAIL race_old_data got=%h exp=%h", d, 32'h0032_0014); end
    checks++; if (ack !== 1'b1) begin fails++; $display("FAIL race_ack got=%b exp=1", ack); end
    bus_read(BASE + 32'h4, d, ack);
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL race_valid_kept got=%h exp=%h", d, 32'h1); end
    bus_read(BASE + 32'h8, d, ack);
    checks++; if (d !== 32'h003C_001E) begin fails++; $display("FAIL race_new_data got=%h exp=%h", d, 32'h003C_001E); end
    bus_read(BASE + 32'h4, d, ack);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL race_valid_clr got=%h exp=0", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic ack;
    pwm_i[0] = 1'b0; tick_n(5);
    pwm_i[0] = 1'b1; tick_n(10);
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    checks++; if (clkgen_en_o !== 1'b0) begin fails++; $display("FAIL rstmid_en got=%b exp=0", clkgen_en_o); end
    bus_read(BASE, d, ack);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL rstmid_ctrl got=%h exp=0", d); end
    bus_read(BASE + 32'h8, d, ack);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL rstmid_ch0 got=%h exp=0", d); end
    bus_read(BASE + 32'h4, d, ack);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL rstmid_status got=%h exp=0", d); end
    pwm_i[0] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; addr_i = 32'd0; data_i = 32'd0; rden_i = 1'b0; wren_i = 1'b0;
    pwm_i = 4'd0; clkgen_i = 8'hFF;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_ctrl();
    test_capture_basic();
    test_overflow();
    test_prescaler();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
